// File: rtl/imem_responder.sv
// imem_responder: instruction-memory responder for the fetch interface.
// Takes one word fetch at a time. After WAIT_CYCLES wait states it returns
// the instruction word with a one-cycle resp_valid pulse. Fetches that are
// misaligned or outside the array window complete with resp_err=1 and a
// zero instruction word. A side load port fills the array.
// Optional build macro IMEM_PERF_EN adds the perf_fetches and perf_errors
// counters and their ports.
module imem_responder #(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    input  logic        flush,
    output logic        resp_valid,
    output logic [31:0] resp_instr,
    output logic [31:0] resp_addr,
    output logic        resp_err,
    input  logic        ld_we,
    input  logic [11:0] ld_idx,
    input  logic [31:0] ld_data
`ifdef IMEM_PERF_EN
    ,
    output logic [31:0] perf_fetches,
    output logic [15:0] perf_errors
`endif
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * DEPTH_WORDS) - 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               accept;
    logic [3:0]         cnt_q;
    logic [31:0]        addr_q;
    logic               err_q;
    logic [31:0]        rd_addr;
    logic               rd_err;
    logic [IDX_W-1:0]   rd_idx;
    logic [31:0]        mem [DEPTH_WORDS];

    // Fetch is illegal when misaligned or outside the window (unsigned, no wrap).
    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < BASE_ADDR) || (a > LAST_ADDR);
    endfunction

    // State register.
    // NOTE: sequential state is updated with <= so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode, handshake and accept strobe.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid && !flush) begin
                    accept  = 1'b1;
                    state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // With zero wait states the response is built on the accept edge, so the
    // read path uses the live request in IDLE and the latched one afterwards.
    assign rd_addr = (state_q == IDLE) ? req_addr : addr_q;
    assign rd_err  = (state_q == IDLE) ? addr_err(req_addr) : err_q;
    assign rd_idx  = IDX_W'((rd_addr - BASE_ADDR) >> 2);

    // Request latch, wait counter and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            resp_instr <= '0;
            resp_addr  <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= req_addr;
                err_q  <= addr_err(req_addr);
                cnt_q  <= 4'(WAIT_CYCLES);
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (state_d == RESP) begin
                resp_instr <= rd_err ? 32'h0000_0000 : mem[rd_idx];
                resp_err   <= rd_err;
                resp_addr  <= rd_addr;
            end
        end
    end

    // Load-port write; indices beyond the array are dropped.
    // NOTE: the array has no reset so it maps onto plain RAM; contents are defined only once loaded.
    always_ff @(posedge clk) begin
        if (ld_we && (32'(ld_idx) < 32'(DEPTH_WORDS))) begin
            mem[ld_idx[IDX_W-1:0]] <= ld_data;
        end
    end

    // A flush seen during the response cycle suppresses the pulse immediately.
    assign resp_valid = (state_q == RESP) && !flush;

`ifdef IMEM_PERF_EN
    // Delivered-fetch and delivered-error counters; the error count saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetches <= '0;
            perf_errors  <= '0;
        end else if (resp_valid) begin
            perf_fetches <= perf_fetches + 32'd1;
            if (resp_err && (perf_errors != 16'hFFFF)) begin
                perf_errors <= perf_errors + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Randomized self-checking bench for imem_responder against a transaction-level
// model: an associative array of loaded words, the address-window rule and
// the wait-state count decide every expected response.
module tb_imem_responder;

    localparam int          W     = 1;
    localparam int          DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        flush;
    logic        resp_valid;
    logic [31:0] resp_instr;
    logic [31:0] resp_addr;
    logic        resp_err;
    logic        ld_we;
    logic [11:0] ld_idx;
    logic [31:0] ld_data;
`ifdef IMEM_PERF_EN
    logic [31:0] perf_fetches;
    logic [15:0] perf_errors;
`endif

    imem_responder #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_instr (resp_instr),
        .resp_addr  (resp_addr),
        .resp_err   (resp_err),
        .ld_we      (ld_we),
        .ld_idx     (ld_idx),
        .ld_data    (ld_data)
`ifdef IMEM_PERF_EN
        ,
        .perf_fetches (perf_fetches),
        .perf_errors  (perf_errors)
`endif
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_mem [int];
    int          written_q [$];
    logic [31:0] last_instr;
    logic [31:0] last_addr;
    logic        last_err;
    int          exp_fetches;
    int          exp_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_err(input logic [31:0] a);
        logic [31:0] top;
        top = BASE + 32'(4 * DEPTH) - 32'd4;
        return (a % 4 != 0) || (a < BASE) || (a > top);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        if (is_err(a)) return 32'h0;
        if (!model_mem.exists(word_of(a))) return 32'hxxxx_xxxx;
        return model_mem[word_of(a)];
    endfunction

    task automatic load_word(input int idx, input logic [31:0] data);
        ld_we   = 1'b1;
        ld_idx  = 12'(idx);
        ld_data = data;
        tick();
        ld_we = 1'b0;
        if (!model_mem.exists(idx)) written_q.push_back(idx);
        model_mem[idx] = data;
    endtask

    // Full fetch; optionally a load-port write to the same word lands on the
    // edge that registers the response.
    task automatic fetch(input logic [31:0] addr, input bit collide, input logic [31:0] coll_data);
        bit          err;
        logic [31:0] exp;
        err = is_err(addr);
        exp = exp_word(addr);
        check("req_ready_idle", req_ready, 1);
        for (int e = 0; e <= W; e++) begin
            if (e == 0) begin
                req_valid = 1'b1;
                req_addr  = addr;
            end
            if (collide && e == W) begin
                ld_we   = 1'b1;
                ld_idx  = 12'(word_of(addr));
                ld_data = coll_data;
            end
            tick();
            req_valid = 1'b0;
            req_addr  = $urandom;
            ld_we     = 1'b0;
            if (e < W) begin
                check("resp_early", resp_valid, 0);
                check("req_ready_wait", req_ready, 0);
            end
        end
        check("resp_valid", resp_valid, 1);
        check("req_ready_resp", req_ready, 0);
        check("resp_instr", resp_instr, exp);
        check("resp_addr", resp_addr, addr);
        check("resp_err", resp_err, err);
        if (collide) model_mem[word_of(addr)] = coll_data;
        last_instr = exp;
        last_addr  = addr;
        last_err   = err;
        exp_fetches++;
        if (err) exp_errors++;
        tick();
        check("resp_pulse_end", resp_valid, 0);
        check("req_ready_after", req_ready, 1);
    endtask

    task automatic check_perf(input string tag);
`ifdef IMEM_PERF_EN
        check({tag, "_fetches"}, perf_fetches, exp_fetches);
        check({tag, "_errors"}, perf_errors, exp_errors);
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    initial begin
        logic [31:0] a;
        int          sel;
        int          idx;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        flush     = 1'b0;
        ld_we     = 1'b0;
        ld_idx    = '0;
        ld_data   = '0;
        exp_fetches = 0;
        exp_errors  = 0;
        last_instr  = '0;
        last_addr   = '0;
        last_err    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_instr", resp_instr, 0);
        check("rst_resp_addr", resp_addr, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_req_ready", req_ready, 1);
        check_perf("rst_perf");

        // Directed contents.
        load_word(0, 32'h3401_0005);
        load_word(1, 32'h0000_000C);
        load_word(2, 32'h0000_0000);
        load_word(4095, 32'hDEAD_BEEF);
        for (int i = 3; i < 32; i++) load_word(i, $urandom);

        // Basic fetches, out-of-window / misaligned fetches, upper boundary.
        fetch(32'h0000_3000, 1'b0, '0);
        fetch(32'h0000_3004, 1'b0, '0);
        fetch(32'h0000_2FFC, 1'b0, '0);
        fetch(32'h0000_7000, 1'b0, '0);
        fetch(32'h0000_3002, 1'b0, '0);
        fetch(32'h0000_6FFC, 1'b0, '0);

        // Flush in IDLE blocks acceptance.
        req_valid = 1'b1;
        req_addr  = 32'h0000_3008;
        flush     = 1'b1;
        tick();
        req_valid = 1'b0;
        flush     = 1'b0;
        check("idle_flush_ready", req_ready, 1);
        tick();
        check("idle_flush_no_resp", resp_valid, 0);

        // Flush during WAIT: no response, ready again next cycle, outputs hold.
        req_valid = 1'b1;
        req_addr  = 32'h0000_3008;
        tick();
        req_valid = 1'b0;
        flush     = 1'b1;
        check("wflush_resp_valid", resp_valid, 0);
        tick();
        flush = 1'b0;
        check("wflush_ready", req_ready, 1);
        check("wflush_resp_valid2", resp_valid, 0);
        check("wflush_hold_addr", resp_addr, last_addr);
        check("wflush_hold_instr", resp_instr, last_instr);
        tick();
        check("wflush_no_late_resp", resp_valid, 0);

        // Flush during RESP: pulse suppressed, then back to IDLE.
        req_valid = 1'b1;
        req_addr  = 32'h0000_3004;
        for (int e = 0; e <= W; e++) begin
            tick();
            req_valid = 1'b0;
        end
        check("rflush_pre", resp_valid, 1);
        flush = 1'b1;
        #1;
        check("rflush_gated", resp_valid, 0);
        check("rflush_addr", resp_addr, 32'h0000_3004);
        last_addr  = 32'h0000_3004;
        last_instr = model_mem[1];
        last_err   = 1'b0;
        tick();
        flush = 1'b0;
        check("rflush_ready", req_ready, 1);
        check("rflush_no_resp", resp_valid, 0);
        check_perf("flush_perf");

        // Write and response-read of the same word on one edge: old data.
        fetch(32'h0000_3008, 1'b1, 32'h1111_1111);
        fetch(32'h0000_3008, 1'b0, '0);

        // Reset during WAIT drops the request.
        req_valid = 1'b1;
        req_addr  = 32'h0000_3000;
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_fetches = 0;
        exp_errors  = 0;
        check("mrst_resp_valid", resp_valid, 0);
        check("mrst_resp_instr", resp_instr, 0);
        check("mrst_resp_addr", resp_addr, 0);
        check("mrst_resp_err", resp_err, 0);
        check("mrst_req_ready", req_ready, 1);
        tick();
        check("mrst_no_resp", resp_valid, 0);

        // Three good and two error fetches.
        fetch(32'h0000_3000, 1'b0, '0);
        fetch(32'h0000_3004, 1'b0, '0);
        fetch(32'h0000_3008, 1'b0, '0);
        fetch(32'h0000_2FFC, 1'b0, '0);
        fetch(32'h0000_7000, 1'b0, '0);
        check_perf("perf_3_2");

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 7);
            idx = written_q[$urandom_range(0, written_q.size() - 1)];
            case (sel)
                0, 1, 2: a = BASE + 32'(4 * idx);
                3:       a = BASE + 32'(4 * idx) + 32'($urandom_range(1, 3));
                4:       a = 32'($urandom_range(0, 32'h2FFF));
                5:       a = 32'h0000_7000 + ($urandom & 32'h0FFF_FFFF);
                6:       a = 32'hFFFF_FFFC - ($urandom & 32'h0000_FFFC);
                default: begin
                    load_word($urandom_range(0, DEPTH - 1), $urandom);
                    a = BASE + 32'(4 * idx);
                end
            endcase
            fetch(a, (sel < 3) && ($urandom_range(0, 3) == 0), $urandom);
            repeat ($urandom_range(0, 2)) tick();
        end
        check_perf("final_perf");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
